// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the state encoding, the counter width rule and the retry-counter helper.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    POR       = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_POR_CYCLES     = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam logic [3:0] RETRY_MAX  = 4'd15;

  // One shared counter serves all states, so it is sized for the longest interval.
  function automatic int cnt_w_f(input int por_c, input int stb_c, input int to_c);
    int m;
    m = por_c;
    if (stb_c > m) begin
      m = stb_c;
    end else begin
      m = m;
    end
    if (to_c > m) begin
      m = to_c;
    end else begin
      m = m;
    end
    return $clog2(m) + 1;
  endfunction

  function automatic logic [3:0] sat_inc4_f(input logic [3:0] v);
    return (v == RETRY_MAX) ? RETRY_MAX : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for single-bit or bundled quasi-static signals.
// Both stages clear to zero on the asynchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability-settling chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer downstream of the system PLL: pulses the PLL reset, waits for a
// debounced lock, then releases the system reset; retries on timeout, re-sequences on loss.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int POR_CYCLES     = DEF_POR_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  localparam int CNT_W = cnt_w_f(POR_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             lk_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             retry_inc_s;
  logic             lost_set_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // Next-state and counter decisions; lock takes priority over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_inc_s = 1'b0;
    lost_set_s  = 1'b0;
    case (state_r)
      POR: begin
        if (cnt_r == POR_LAST) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = POR;
          cnt_nxt_s   = CNT_ZERO;
          retry_inc_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == STB_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nxt_s = POR;
          cnt_nxt_s   = CNT_ZERO;
          lost_set_s  = 1'b1;
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = POR;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and shared counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= POR;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      retry_cnt <= 4'd0;
      lock_lost <= 1'b0;
    end else begin
      pll_rst   <= (state_nxt_s == POR);
      sys_rst   <= (state_nxt_s != RUN);
      ready     <= (state_nxt_s == RUN);
      retry_cnt <= retry_inc_s ? sat_inc4_f(retry_cnt) : retry_cnt;
      lock_lost <= lock_lost | lost_set_s;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: a phase/elapsed-time reference model queues the
// expected outputs after every refclk edge; a negedge monitor pops and compares them.
module tb_pll_reset_seq;

  localparam int POR_C = 4;
  localparam int STB_C = 8;
  localparam int TO_C  = 32;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry;
    logic       lost;
  } obs_t;

  obs_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    running = 1'b0;

  // Reference model: named phase, cycles spent in it, and the last two lock samples.
  string ph;
  int    age;
  int    m_retry;
  bit    m_lost;
  bit    h_old;
  bit    h_new;

  pll_reset_seq #(
    .POR_CYCLES     (POR_C),
    .STABLE_CYCLES  (STB_C),
    .TIMEOUT_CYCLES (TO_C)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  always #5 refclk = ~refclk;

  function automatic void model_reset();
    ph = "POR"; age = 0; m_retry = 0; m_lost = 1'b0; h_old = 1'b0; h_new = 1'b0;
  endfunction

  function automatic void enter(input string p);
    ph = p; age = 0;
  endfunction

  // One refclk edge: lock seen by the sequencer is the input from two edges earlier.
  function automatic void model_step(input bit lk_in, input bit rn_in);
    bit lk;
    if (!rn_in) begin
      model_reset();
      return;
    end
    lk = h_old; h_old = h_new; h_new = lk_in;
    if (ph == "POR") begin
      age++;
      if (age == POR_C) enter("WAIT");
    end else if (ph == "WAIT") begin
      if (lk) enter("STABLE");
      else begin
        age++;
        if (age == TO_C) begin
          enter("POR");
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        end
      end
    end else if (ph == "STABLE") begin
      if (!lk) enter("WAIT");
      else begin
        age++;
        if (age == STB_C) enter("RUN");
      end
    end else begin
      if (!lk) begin
        enter("POR");
        m_lost = 1'b1;
      end
    end
  endfunction

  function automatic obs_t expected();
    obs_t e;
    e.pll_rst = (ph == "POR");
    e.sys_rst = (ph != "RUN");
    e.ready   = (ph == "RUN");
    e.retry   = 4'(m_retry);
    e.lost    = m_lost;
    return e;
  endfunction

  task automatic cycle(input bit lk_in, input bit rn_in);
    pll_locked = lk_in;
    rst_n      = rn_in;
    @(posedge refclk);
    #1;
    model_step(lk_in, rn_in);
    exp_q.push_back(expected());
    running = 1'b1;
  endtask

  // Assert rst_n between edges; the pending expectation becomes the reset values.
  task automatic drop_now();
    #1;
    rst_n = 1'b0;
    model_reset();
    void'(exp_q.pop_back());
    exp_q.push_back(expected());
  endtask

  task automatic run_until(input string p, input int a, input bit lk_in, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (ph == p && age == a) found = 1'b1;
      else cycle(lk_in, 1'b1);
    end
    if (!found && !(ph == p && age == a)) begin
      n_tests++;
      n_fail++;
      $display("FAIL reach_%s act=%s/%0d exp=%s/%0d", p, ph, age, p, a);
    end
  endtask

  always @(negedge refclk) begin
    obs_t a;
    obs_t e;
    a = {pll_rst, sys_rst, ready, retry_cnt, lock_lost};
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t act pll_rst=%b sys_rst=%b ready=%b retry=%0d lost=%b exp pll_rst=%b sys_rst=%b ready=%b retry=%0d lost=%b",
                 $time, a.pll_rst, a.sys_rst, a.ready, a.retry, a.lost,
                 e.pll_rst, e.sys_rst, e.ready, e.retry, e.lost);
      end
    end else if (running) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t act=0 exp>=1 entries", $time);
    end
  end

  initial begin
    int r;
    int len;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0);
    // Cold start.
    repeat (10) cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b1, 1'b1);
    // Lock loss in RUN.
    cycle(1'b0, 1'b1);
    repeat (30) cycle(1'b1, 1'b1);
    // Timeout once, then a glitchy lock.
    repeat (40) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (25) cycle(1'b1, 1'b1);
    // Mid-sequence reset in STABLE with five cycles elapsed.
    cycle(1'b0, 1'b1);
    run_until("STABLE", 5, 1'b1, 200);
    drop_now();
    repeat (2) cycle(1'b0, 1'b0);
    // Lock seen on the timeout cycle of WAIT_LOCK.
    run_until("WAIT", 29, 1'b0, 200);
    repeat (20) cycle(1'b1, 1'b1);
    // Retry counter saturation.
    repeat (600) cycle(1'b0, 1'b1);
    // Randomised segments.
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drop_now();
        len = $urandom_range(1, 3);
        repeat (len) cycle(1'($urandom_range(0, 1)), 1'b0);
      end else if (r < 5) begin
        len = $urandom_range(1, 40);
        repeat (len) cycle(1'b1, 1'b1);
      end else begin
        len = $urandom_range(1, 50);
        repeat (len) cycle(1'b0, 1'b1);
      end
    end
    repeat (5) cycle(1'b1, 1'b1);
    @(negedge refclk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain act=%0d exp=0 entries", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
